axi4_slave_mem: RTL and testbench
=================================

Name:
axi4_slave_mem

Overview:
AXI4 full-protocol slave with an internal word-addressed memory. It serves as the bus endpoint that a bus master (the axi_master block) talks to over the axi_if channel bundle. It accepts independent write and read bursts (FIXED/INCR/WRAP) and returns OKAY/SLVERR responses. It is the memory-side partner used in the AXI master/slave loopback bench.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data bus width (32 or 64)
ID_W, 4, transaction ID width
MEM_DEPTH, 1024, number of DATA_W-bit memory words

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address payload
awvalid in 1, awready out 1  AW handshake
wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data payload
wvalid in 1, wready out 1  W handshake
bid/bresp  out  ID_W/2  write response payload
bvalid out 1, bready in 1  B handshake
arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address payload
arvalid in 1, arready out 1  AR handshake
rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data payload
rvalid out 1, rready in 1  R handshake

Behaviour:
- Reset (rst=1 at clk edge): awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0; both FSMs go idle. Memory contents are not reset. A reset mid-burst aborts the burst with no response issued.
- The write FSM (W_IDLE, W_DATA, W_RESP) and the read FSM (R_IDLE, R_DATA) run fully independently.
- W_IDLE: awready=1. On awvalid&awready, latch id/addr/len/size/burst, clear the error flag, and go to W_DATA. The next cycle has awready=0 and wready=1.
- W_DATA: each wvalid&wready beat writes the bytes enabled by wstrb at word index addr>>log2(DATA_W/8), then advances the address. On beat number awlen (0-based), go to W_RESP, drop wready, and assert bvalid the next cycle.
- W_RESP: hold bid and bresp stable until bready. Then go to W_IDLE with awready=1 the next cycle.
- Read R_IDLE: arready=1. On handshake, latch the payload and go to R_DATA. rvalid and the first rdata appear the next cycle (latency 1).
- R_DATA: rdata/rresp/rlast stay stable while rvalid&!rready. On rvalid&rready, present the next beat the following cycle with no bubble. rlast=1 only on beat arlen. After the last handshake, rvalid=0 and arready=1.
- Address step:
  - FIXED: no change.
  - INCR: addr += 1<<size.
  - WRAP: wrap boundary = (len+1)<<size, aligned down.
- SLVERR (response 2'b10) conditions; otherwise OKAY (2'b00):
  - Beat address ≥ MEM_DEPTH*DATA_W/8: write dropped, read data = 0.
  - size > log2(DATA_W/8): handled as full width.
  - WRAP with len not in {1,3,7,15}: handled as INCR.
  - wlast value mismatching the beat count; the beat count governs.
- Write response: bresp = SLVERR if any beat of the burst erred.
- Read response: rresp is per beat.
- A read and a write to the same word in the same cycle: the read returns the old data.
- INCR bursts crossing 4 KB are not checked.

Decomposition:
- Shared package axi_pkg: burst_t enum (FIXED=0, INCR=1, WRAP=2), resp_t (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), the write and read FSM state enums, and the default widths.
- One natural sub-module: axi_burst_addr, a combinational next-address calculator (addr, size, len, burst -> next_addr) instantiated once per FSM.

Test Plan:
- Single write then read: AW addr 0x10, len 0, size 2, INCR; W 0xDEADBEEF, strb 0xF -> bresp 0, bid echoed. AR same address -> rdata 0xDEADBEEF, rresp 0, rlast 1.
- INCR burst: addr 0x100, len 3, data 1..4 -> read back 1,2,3,4 with rlast only on beat 4. Partial write strb 0x3 with 0xAAAA5555 over 0xDEADBEEF -> 0xDEAD5555.
- WRAP: addr 0x208, len 3, size 2 -> beats hit 0x208, 0x20C, 0x200, 0x204. FIXED len 3 -> only the last data remains at the address.
- Out of range: write and read at 0x1000 (MEM_DEPTH 1024) -> bresp 2, rresp 2, rdata 0; memory unchanged.
- Backpressure: hold bready=0 for 5 cycles -> bvalid held and awready=0. Hold rready low mid-burst -> rdata stable, no beat lost.
- Reset during a W_DATA burst -> no bvalid; awready=arready=1 after reset; a new transaction completes normally.

Source files
------------

// File: rtl/axi4_slave_mem_pkg.sv
// rtl/axi4_slave_mem_pkg.sv - shared types, default widths and helpers for the AXI4 memory slave
package axi4_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ID_W      = 4;
  localparam int DEF_MEM_DEPTH = 1024;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Oversized beats are clamped to the bus width.
  function automatic logic [2:0] eff_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi4_slave_mem_if.sv
// rtl/axi4_slave_mem_if.sv - AXI4 channel bundle with master and slave views
interface axi4_slave_mem_if
  import axi4_slave_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = DEF_ID_W
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

endinterface

// File: rtl/axi4_slave_mem_burst_addr.sv
// rtl/axi4_slave_mem_burst_addr.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi4_slave_mem_burst_addr
  import axi4_slave_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  burst_t            burst,
  output logic [ADDR_W-1:0] next_addr
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

  logic [2:0]        esize;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    esize     = eff_size(size, MAX_SIZE);
    incr_addr = addr + (ADDR_W'(1) << esize);
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << esize) - ADDR_W'(1);
    next_addr = incr_addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      // Illegal wrap lengths fall through to INCR stepping.
      BURST_WRAP: begin
        if (wrap_len_ok(len)) begin
          next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end
      end
      default: next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 slave with internal word memory and independent read/write FSMs
module axi4_slave_mem
  import axi4_slave_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ID_W      = DEF_ID_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input logic             clk,
  input logic             rst,
  axi4_slave_mem_if.slave bus
);
  localparam int                STRB_W    = DATA_W / 8;
  localparam int                OFF_W     = $clog2(STRB_W);
  localparam int                IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [2:0]        MAX_SIZE  = 3'(OFF_W);
  localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_DEPTH * STRB_W);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return a >= MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic fmt_err(input logic [2:0] size, input logic [7:0] len, input burst_t burst);
    return (size > MAX_SIZE) || ((burst == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  // ---------------- write channel ----------------
  w_state_t          w_state, w_state_nxt;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr, w_next;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  burst_t            w_burst;
  logic              w_err;
  logic [ID_W-1:0]   bid_q;
  resp_t             bresp_q;
  logic              aw_hs, w_hs, w_last_beat, w_beat_err;

  assign aw_hs       = bus.awvalid && (w_state == W_IDLE);
  assign w_hs        = bus.wvalid && (w_state == W_DATA);
  assign w_last_beat = (w_cnt == w_len);
  // The beat count ends the burst; a disagreeing wlast only flags the error.
  assign w_beat_err  = addr_oor(w_addr) || fmt_err(w_size, w_len, w_burst) ||
                       (bus.wlast != w_last_beat);

  axi4_slave_mem_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_addr (
    .addr      (w_addr),
    .size      (w_size),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.awready = 1'b1;
        if (bus.awvalid) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid && w_last_beat) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= BURST_FIXED;
      w_err   <= 1'b0;
      bid_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        w_id    <= bus.awid;
        w_addr  <= bus.awaddr;
        w_len   <= bus.awlen;
        w_size  <= bus.awsize;
        w_burst <= burst_t'(bus.awburst);
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= w_next;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err || w_beat_err;
        if (w_last_beat) begin
          bid_q   <= w_id;
          bresp_q <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_hs && !addr_oor(w_addr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (bus.wstrb[i]) mem[word_idx(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.bid   = bid_q;
  assign bus.bresp = bresp_q;

  // ---------------- read channel ----------------
  r_state_t          r_state, r_state_nxt;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] r_addr, r_next, rd_addr;
  logic [7:0]        r_len, r_cnt, rd_len;
  logic [2:0]        r_size, rd_size;
  burst_t            r_burst, rd_burst;
  logic [DATA_W-1:0] rdata_q, rd_word;
  resp_t             rresp_q;
  logic              rlast_q, rd_err, ar_hs, r_hs, r_load;

  assign ar_hs  = bus.arvalid && (r_state == R_IDLE);
  assign r_hs   = bus.rready && (r_state == R_DATA);
  assign r_load = ar_hs || (r_hs && !rlast_q);

  axi4_slave_mem_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_addr (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next)
  );

  // One read port: the first beat reads the AR address, later beats the stepped address.
  always_comb begin
    rd_addr  = r_next;
    rd_size  = r_size;
    rd_len   = r_len;
    rd_burst = r_burst;
    if (r_state == R_IDLE) begin
      rd_addr  = bus.araddr;
      rd_size  = bus.arsize;
      rd_len   = bus.arlen;
      rd_burst = burst_t'(bus.arburst);
    end
    rd_err  = addr_oor(rd_addr) || fmt_err(rd_size, rd_len, rd_burst);
    rd_word = addr_oor(rd_addr) ? '0 : mem[word_idx(rd_addr)];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        bus.arready = 1'b1;
        if (bus.arvalid) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        if (bus.rready && rlast_q) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rid_q   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= BURST_FIXED;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      if (ar_hs) begin
        rid_q   <= bus.arid;
        r_len   <= bus.arlen;
        r_size  <= bus.arsize;
        r_burst <= burst_t'(bus.arburst);
        r_cnt   <= '0;
        rlast_q <= (bus.arlen == 8'd0);
      end else if (r_hs) begin
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= !rlast_q && ((r_cnt + 8'd1) == r_len);
      end
      if (r_load) begin
        r_addr  <= rd_addr;
        rdata_q <= rd_word;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign bus.rid   = rid_q;
  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;
  assign bus.rlast = rlast_q;

endmodule

// File: tb/tb_axi4_slave_mem.sv
// tb/tb_axi4_slave_mem.sv - directed self-checking bench for axi4_slave_mem
module tb_axi4_slave_mem;
  import axi4_slave_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_slave_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

  axi4_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_DEPTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  bit tmo;
  bit stall_ok;
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit hs;
    n = 0;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    do begin
      @(negedge clk); hs = bus.awready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    if (!hs) tmo = 1'b1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit hs;
    n = 0;
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    do begin
      @(negedge clk); hs = bus.arready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 50);
    if (!hs) tmo = 1'b1;
    bus.arvalid = 1'b0;
  endtask

  task automatic send_w(input int nbeats, input int last_at);
    int n;
    bit hs;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      bus.wdata = wr_data[i]; bus.wstrb = wr_strb[i]; bus.wlast = (i == last_at);
      bus.wvalid = 1'b1;
      do begin
        @(negedge clk); hs = bus.wready;
        @(posedge clk); #1; n++;
      end while (!hs && n < 50);
      if (!hs) begin tmo = 1'b1; break; end
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic recv_b();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) tmo = 1'b1;
    b_resp = bus.bresp;
    b_id   = bus.bid;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic recv_r(input int nbeats, input int stall_beat, input int stall_cyc);
    int n;
    logic [31:0] d;
    logic l;
    stall_ok = 1'b1;
    bus.rready = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      n = 0;
      if (k == stall_beat) bus.rready = 1'b0;
      @(negedge clk);
      while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
      if (!bus.rvalid) begin tmo = 1'b1; break; end
      if (k == stall_beat) begin
        d = bus.rdata; l = bus.rlast;
        repeat (stall_cyc) begin
          @(negedge clk);
          if (bus.rdata !== d || bus.rvalid !== 1'b1 || bus.rlast !== l) stall_ok = 1'b0;
        end
        bus.rready = 1'b1;
      end
      if (k == 0) rd_id = bus.rid;
      rd_data[k] = bus.rdata;
      rd_resp[k] = bus.rresp;
      rd_last[k] = bus.rlast;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    tmo = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL reset_awready: got %b want 1", bus.awready); end
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", bus.arready); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL reset_wready: got %b want 0", bus.wready); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL reset_bvalid: got %b want 0", bus.bvalid); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
    checks++; if (bus.rlast !== 1'b0) begin errors++; $display("FAIL reset_rlast: got %b want 0", bus.rlast); end
    checks++; if (bus.bresp !== 2'd0 || bus.rresp !== 2'd0) begin errors++; $display("FAIL reset_resp: got b=%0d r=%0d want 0/0", bus.bresp, bus.rresp); end
    checks++; if (bus.bid !== 4'd0 || bus.rid !== 4'd0) begin errors++; $display("FAIL reset_ids: got b=%0d r=%0d want 0/0", bus.bid, bus.rid); end
    checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    tmo = 1'b0;
    wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    send_aw(4'd5, 32'h10, 8'd0, 3'd2, 2'd1); send_w(1, 0); recv_b();
    checks++; if (b_resp !== 2'd0) begin errors++; $display("FAIL single_bresp: got %0d want 0", b_resp); end
    checks++; if (b_id !== 4'd5) begin errors++; $display("FAIL single_bid: got %0d want 5", b_id); end
    send_ar(4'd6, 32'h10, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_data[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rd_data[0]); end
    checks++; if (rd_resp[0] !== 2'd0 || rd_last[0] !== 1'b1) begin errors++; $display("FAIL single_rresp_rlast: got %0d/%b want 0/1", rd_resp[0], rd_last[0]); end
    checks++; if (rd_id !== 4'd6) begin errors++; $display("FAIL single_rid: got %0d want 6", rd_id); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL single_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_incr_burst();
    tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
    send_aw(4'd1, 32'h100, 8'd3, 3'd2, 2'd1); send_w(4, 3); recv_b();
    checks++; if (b_resp !== 2'd0) begin errors++; $display("FAIL incr_bresp: got %0d want 0", b_resp); end
    send_ar(4'd2, 32'h100, 8'd3, 3'd2, 2'd1); recv_r(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'd0) begin
        errors++; $display("FAIL incr_beat%0d: got %h last=%b resp=%0d want %h last=%b resp=0", i, rd_data[i], rd_last[i], rd_resp[i], i + 1, i == 3);
      end
    end
    wr_data[0] = 32'hAAAA5555; wr_strb[0] = 4'h3;
    send_aw(4'd3, 32'h10, 8'd0, 3'd2, 2'd1); send_w(1, 0); recv_b();
    send_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_data[0] !== 32'hDEAD5555) begin errors++; $display("FAIL partial_strb: got %h want dead5555", rd_data[0]); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL incr_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_wrap_fixed();
    logic [31:0] exp_v [4];
    tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0A00000 + 32'(i); wr_strb[i] = 4'hF; end
    send_aw(4'd4, 32'h208, 8'd3, 3'd2, 2'd2); send_w(4, 3); recv_b();
    checks++; if (b_resp !== 2'd0) begin errors++; $display("FAIL wrap_bresp: got %0d want 0", b_resp); end
    exp_v[0] = 32'hA0A00002; exp_v[1] = 32'hA0A00003; exp_v[2] = 32'hA0A00000; exp_v[3] = 32'hA0A00001;
    send_ar(4'd4, 32'h200, 8'd3, 3'd2, 2'd1); recv_r(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== exp_v[i]) begin errors++; $display("FAIL wrap_write_word%0d: got %h want %h", i, rd_data[i], exp_v[i]); end
    end
    send_ar(4'd4, 32'h208, 8'd3, 3'd2, 2'd2); recv_r(4, -1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== wr_data[i]) begin errors++; $display("FAIL wrap_read_beat%0d: got %h want %h", i, rd_data[i], wr_data[i]); end
    end
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hB0B00000 + 32'(i);
    send_aw(4'd5, 32'h300, 8'd3, 3'd2, 2'd0); send_w(4, 3); recv_b();
    send_ar(4'd5, 32'h300, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_data[0] !== 32'hB0B00003) begin errors++; $display("FAIL fixed_last_wins: got %h want b0b00003", rd_data[0]); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL wrap_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_out_of_range();
    tmo = 1'b0;
    wr_data[0] = 32'h11111111; wr_strb[0] = 4'hF;
    send_aw(4'd0, 32'h0, 8'd0, 3'd2, 2'd1); send_w(1, 0); recv_b();
    wr_data[0] = 32'h5A5A5A5A;
    send_aw(4'd9, 32'h1000, 8'd0, 3'd2, 2'd1); send_w(1, 0); recv_b();
    checks++; if (b_resp !== 2'd2 || b_id !== 4'd9) begin errors++; $display("FAIL oor_bresp: got %0d id %0d want 2 id 9", b_resp, b_id); end
    send_ar(4'd9, 32'h1000, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_resp[0] !== 2'd2 || rd_data[0] !== 32'd0) begin errors++; $display("FAIL oor_read: got resp %0d data %h want 2/0", rd_resp[0], rd_data[0]); end
    send_ar(4'd0, 32'h0, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_data[0] !== 32'h11111111) begin errors++; $display("FAIL oor_mem_unchanged: got %h want 11111111", rd_data[0]); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL oor_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_protocol_errors();
    tmo = 1'b0;
    wr_data[0] = 32'h0000AAAA; wr_data[1] = 32'h0000BBBB; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
    send_aw(4'd7, 32'h80, 8'd1, 3'd2, 2'd1); send_w(2, 0); recv_b();
    checks++; if (b_resp !== 2'd2) begin errors++; $display("FAIL wlast_mismatch_bresp: got %0d want 2", b_resp); end
    send_ar(4'd7, 32'h80, 8'd1, 3'd2, 2'd1); recv_r(2, -1, 0);
    checks++; if (rd_data[0] !== 32'h0000AAAA || rd_data[1] !== 32'h0000BBBB) begin errors++; $display("FAIL wlast_mismatch_data: got %h %h want 0000aaaa 0000bbbb", rd_data[0], rd_data[1]); end
    checks++; if (rd_last[1] !== 1'b1 || rd_last[0] !== 1'b0) begin errors++; $display("FAIL len1_rlast: got %b%b want 01", rd_last[0], rd_last[1]); end
    send_ar(4'd7, 32'h80, 8'd0, 3'd3, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_resp[0] !== 2'd2 || rd_data[0] !== 32'h0000AAAA) begin errors++; $display("FAIL bad_size_read: got resp %0d data %h want 2/0000aaaa", rd_resp[0], rd_data[0]); end
    send_ar(4'd7, 32'h80, 8'd2, 3'd2, 2'd2); recv_r(3, -1, 0);
    checks++; if (rd_resp[1] !== 2'd2 || rd_data[1] !== 32'h0000BBBB) begin errors++; $display("FAIL bad_wrap_len: got resp %0d data %h want 2/0000bbbb", rd_resp[1], rd_data[1]); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL proto_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_backpressure();
    int bad;
    int n;
    tmo = 1'b0;
    bad = 0;
    n = 0;
    wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
    send_aw(4'd8, 32'h40, 8'd0, 3'd2, 2'd1); send_w(1, 0);
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bus.bvalid) tmo = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.bid !== 4'd8) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b_hold: got %0d bad cycles want 0", bad); end
    @(posedge clk); #1;
    recv_b();
    checks++; if (b_resp !== 2'd0 || b_id !== 4'd8) begin errors++; $display("FAIL b_after_hold: got %0d id %0d want 0 id 8", b_resp, b_id); end
    @(negedge clk);
    checks++; if (bus.awready !== 1'b1 || bus.bvalid !== 1'b0) begin errors++; $display("FAIL b_release: got awready=%b bvalid=%b want 1/0", bus.awready, bus.bvalid); end
    @(posedge clk); #1;
    send_ar(4'd2, 32'h100, 8'd3, 3'd2, 2'd1); recv_r(4, 1, 3);
    checks++; if (stall_ok !== 1'b1) begin errors++; $display("FAIL r_stall_stable: got %b want 1", stall_ok); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_data[i] !== 32'(i + 1)) begin errors++; $display("FAIL r_stall_beat%0d: got %h want %h", i, rd_data[i], i + 1); end
    end
    @(negedge clk);
    checks++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin errors++; $display("FAIL r_done: got rvalid=%b arready=%b want 0/1", bus.rvalid, bus.arready); end
    @(posedge clk); #1;
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL bp_timeout: got %b want 0", tmo); end
  endtask

  task automatic test_reset_mid_burst();
    int bad;
    tmo = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin wr_data[i] = 32'h77770000 + 32'(i); wr_strb[i] = 4'hF; end
    send_aw(4'd7, 32'h500, 8'd3, 3'd2, 2'd1); send_w(2, 3);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.bvalid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL reset_mid_bvalid: got %0d cycles want 0", bad); end
    checks++; if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got aw=%b ar=%b want 1/1", bus.awready, bus.arready); end
    @(posedge clk); #1;
    wr_data[0] = 32'hCAFEF00D;
    send_aw(4'd3, 32'h500, 8'd0, 3'd2, 2'd1); send_w(1, 0); recv_b();
    checks++; if (b_resp !== 2'd0 || b_id !== 4'd3) begin errors++; $display("FAIL reset_mid_new_b: got %0d id %0d want 0 id 3", b_resp, b_id); end
    send_ar(4'd3, 32'h500, 8'd0, 3'd2, 2'd1); recv_r(1, -1, 0);
    checks++; if (rd_data[0] !== 32'hCAFEF00D || rd_resp[0] !== 2'd0) begin errors++; $display("FAIL reset_mid_new_r: got %h resp %0d want cafef00d/0", rd_data[0], rd_resp[0]); end
    checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_mid_timeout: got %b want 0", tmo); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_wrap_fixed();
    test_out_of_range();
    test_protocol_errors();
    test_backpressure();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
